// File: rtl/text_writer_pkg.sv
// Shared constants for the text page writer: page geometry, command codes and FSM states.
package text_writer_pkg;

    localparam int COLUMNS   = 80;
    localparam int ROWS      = 51;
    localparam int ROW_SIZE  = 80;
    localparam int PAGE_SIZE = ROWS * ROW_SIZE;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] TW_WRITE_CELL = 2'd0;
    localparam logic [1:0] TW_FILL_ROW   = 2'd1;
    localparam logic [1:0] TW_FILL_PAGE  = 2'd2;
    localparam logic [1:0] TW_NOP        = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_REQUEST,
        ST_BURST,
        ST_WAIT_DONE
    } tw_state_t;

endpackage

// File: rtl/text_row_address.sv
// Combinational SDRAM address of a text cell inside the circular page ring.
// Shared between the writer and any reader-side address logic.
module text_row_address
    import text_writer_pkg::*;
(
    input  logic [22:0] base_address,
    input  logic [22:0] first_row,
    input  logic [5:0]  row,
    input  logic [6:0]  col,
    output logic [22:0] address
);

    logic [23:0] row_offset;
    logic [23:0] unwrapped;
    logic [23:0] page_limit;
    logic [23:0] wrapped;

    // row*80 as shifts; the column is added after the wrap since a row never straddles it
    always_comb begin
        row_offset = ({18'd0, row} << 6) + ({18'd0, row} << 4);
        unwrapped  = {1'b0, first_row} + row_offset;
        page_limit = {1'b0, base_address} + 24'(PAGE_SIZE);
        wrapped    = (unwrapped >= page_limit) ? (unwrapped - 24'(PAGE_SIZE)) : unwrapped;
        address    = 23'(wrapped + {17'd0, col});
    end

endmodule

// File: rtl/text_writer.sv
// Turns terminal cell/row/page commands into SDRAM write bursts into the circular text page.
// Build option TEXT_WRITER_FILL_PAGE_EN enables FILL_PAGE; otherwise FILL_PAGE is discarded.
module text_writer
    import text_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] base_address,
    input  logic [22:0] first_row,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_row,
    input  logic [6:0]  cmd_col,
    input  logic [31:0] cmd_data,
    output logic        wr_request,
    output logic [22:0] wr_address,
    output logic [8:0]  wr_burst_length,
    output logic [31:0] wr_data,
    input  logic        wr_next,
    input  logic        wr_done,
    output logic        busy
);

    tw_state_t   state;
    tw_state_t   next_state;
    logic [1:0]  op_q;
    logic [5:0]  row_q;
    logic [6:0]  col_q;
    logic [8:0]  word_count;
    logic [22:0] row_address;
    logic        cmd_fire;
    logic        cmd_is_valid;
    logic        last_word;
    logic        row_done;
    logic        more_rows;

    text_row_address u_row_address (
        .base_address (base_address),
        .first_row    (first_row),
        .row          (row_q),
        .col          (col_q),
        .address      (row_address)
    );

    assign cmd_ready  = (state == ST_IDLE) ? TRUE : FALSE;
    assign busy       = (state != ST_IDLE);
    assign wr_request = (state == ST_REQUEST);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign last_word  = (state == ST_BURST) && wr_next && (word_count == wr_burst_length - 9'd1);
    assign row_done   = wr_done && ((state == ST_WAIT_DONE) || last_word);

`ifdef TEXT_WRITER_FILL_PAGE_EN
    assign more_rows = (op_q == TW_FILL_PAGE) && (row_q < 6'(ROWS - 1));
`else
    assign more_rows = FALSE;
`endif

    // Commands that would produce no useful traffic are accepted and dropped in IDLE
    always_comb begin
        cmd_is_valid = FALSE;
        case (cmd_op)
            TW_WRITE_CELL: cmd_is_valid = (cmd_row < 6'(ROWS)) && (cmd_col < 7'(COLUMNS));
            TW_FILL_ROW:   cmd_is_valid = (cmd_row < 6'(ROWS));
`ifdef TEXT_WRITER_FILL_PAGE_EN
            TW_FILL_PAGE:  cmd_is_valid = (cmd_row < 6'(ROWS));
`endif
            default:       cmd_is_valid = FALSE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire && cmd_is_valid) begin
                    next_state = ST_ADDR;
                end
            end
            ST_ADDR:    next_state = ST_REQUEST;
            ST_REQUEST: next_state = ST_BURST;
            ST_BURST: begin
                if (row_done) begin
                    next_state = more_rows ? ST_ADDR : ST_IDLE;
                end else if (last_word) begin
                    next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (row_done) begin
                    next_state = more_rows ? ST_ADDR : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // base_address/first_row are only looked at in ADDR, so each row of a page fill sees fresh values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q            <= TW_NOP;
            row_q           <= '0;
            col_q           <= '0;
            word_count      <= '0;
            wr_address      <= '0;
            wr_burst_length <= '0;
            wr_data         <= '0;
        end else begin
            if (cmd_fire && cmd_is_valid) begin
                op_q    <= cmd_op;
                row_q   <= (cmd_op == TW_FILL_PAGE) ? 6'd0 : cmd_row;
                col_q   <= (cmd_op == TW_WRITE_CELL) ? cmd_col : 7'd0;
                wr_data <= cmd_data;
            end
            if (state == ST_ADDR) begin
                wr_address      <= row_address;
                wr_burst_length <= (op_q == TW_WRITE_CELL) ? 9'd1 : 9'(COLUMNS);
                word_count      <= '0;
            end
            if ((state == ST_BURST) && wr_next) begin
                word_count <= word_count + 9'd1;
            end
`ifdef TEXT_WRITER_FILL_PAGE_EN
            if (row_done && more_rows) begin
                row_q <= row_q + 6'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer with a simple SDRAM write-port model.
module tb_text_writer;

    localparam int ROWS    = 51;
    localparam int COLUMNS = 80;

    logic        clk;
    logic        reset;
    logic [22:0] base_address;
    logic [22:0] first_row;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_row;
    logic [6:0]  cmd_col;
    logic [31:0] cmd_data;
    logic        wr_request;
    logic [22:0] wr_address;
    logic [8:0]  wr_burst_length;
    logic [31:0] wr_data;
    logic        wr_next;
    logic        wr_done;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int req_count  = 0;

    text_writer dut (
        .clk             (clk),
        .reset           (reset),
        .base_address    (base_address),
        .first_row       (first_row),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_row         (cmd_row),
        .cmd_col         (cmd_col),
        .cmd_data        (cmd_data),
        .wr_request      (wr_request),
        .wr_address      (wr_address),
        .wr_burst_length (wr_burst_length),
        .wr_data         (wr_data),
        .wr_next         (wr_next),
        .wr_done         (wr_done),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_request === 1'b1) req_count <= req_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no completion, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] row, input logic [6:0] col,
                            input logic [31:0] data);
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_data  = data;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Called with the DUT in BURST; plays the controller side for one burst
    task automatic drive_burst(input int len, input logic [31:0] data, input int stall_max,
                               input bit done_with_last, input bit probe_early_done,
                               output int words, output int data_bad, output logic probe_busy);
        words      = 0;
        data_bad   = 0;
        probe_busy = 1'b1;
        for (int w = 0; w < len; w++) begin
            int stall;
            stall = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            repeat (stall) step();
            if (probe_early_done && (w == len - 1)) begin
                wr_done = 1'b1;
                step();
                wr_done    = 1'b0;
                probe_busy = busy;
            end
            if (wr_data !== data) data_bad++;
            wr_next = 1'b1;
            if (done_with_last && (w == len - 1)) wr_done = 1'b1;
            step();
            wr_next = 1'b0;
            wr_done = 1'b0;
            words++;
        end
        if (!done_with_last) begin
            wr_next = 1'b1;
            step();
            wr_next = 1'b0;
            wr_done = 1'b1;
            step();
            wr_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'd3;
        cmd_row      = '0;
        cmd_col      = '0;
        cmd_data     = '0;
        wr_next      = 1'b0;
        wr_done      = 1'b0;
        base_address = 23'h1000;
        first_row    = 23'h1000;
        repeat (3) step();
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
        compared++; if (wr_request !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_request: got %b, required 0", wr_request); end
        compared++; if (wr_address !== 23'h0) begin mismatched++; $display("[TB] FAIL reset_wr_address: got %h, required 0", wr_address); end
        compared++; if (wr_burst_length !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_burst_length: got %0d, required 0", wr_burst_length); end
        compared++; if (wr_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_wr_data: got %h, required 0", wr_data); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_write_cell();
        int words, bad;
        logic probe;
        base_address = 23'h1000;
        first_row    = 23'h1000;
        send_cmd(2'd0, 6'd0, 7'd5, 32'h0041_0F00);
        compared++; if (wr_request !== 1'b0) begin mismatched++; $display("[TB] FAIL wc_request_early: got %b, required 0", wr_request); end
        compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL wc_ready_drop: got %b, required 0", cmd_ready); end
        step();
        compared++; if (wr_request !== 1'b1) begin mismatched++; $display("[TB] FAIL wc_request_latency: got %b, required 1", wr_request); end
        compared++; if (wr_address !== 23'h1005) begin mismatched++; $display("[TB] FAIL wc_address: got %h, required 1005", wr_address); end
        compared++; if (wr_burst_length !== 9'd1) begin mismatched++; $display("[TB] FAIL wc_length: got %0d, required 1", wr_burst_length); end
        step();
        compared++; if (wr_request !== 1'b0) begin mismatched++; $display("[TB] FAIL wc_request_pulse: got %b, required 0", wr_request); end
        drive_burst(1, 32'h0041_0F00, 0, 1'b0, 1'b0, words, bad, probe);
        compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL wc_data: got %0d bad words, required 0", bad); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL wc_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_fill_row_wrap();
        int words, bad, req_before;
        logic probe;
        base_address = 23'h1000;
        first_row    = 23'h1000 + 23'd4000;
        req_before   = req_count;
        send_cmd(2'd1, 6'd3, 7'd9, 32'hDEAD_BEEF);
        step();
        compared++; if (wr_request !== 1'b1) begin mismatched++; $display("[TB] FAIL fr_request_latency: got %b, required 1", wr_request); end
        compared++; if (wr_address !== 23'h10A0) begin mismatched++; $display("[TB] FAIL fr_wrap_address: got %h, required 10a0", wr_address); end
        compared++; if (wr_burst_length !== 9'd80) begin mismatched++; $display("[TB] FAIL fr_length: got %0d, required 80", wr_burst_length); end
        step();
        drive_burst(COLUMNS, 32'hDEAD_BEEF, 5, 1'b0, 1'b1, words, bad, probe);
        compared++; if (words !== 80) begin mismatched++; $display("[TB] FAIL fr_word_count: got %0d, required 80", words); end
        compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL fr_data: got %0d bad words, required 0", bad); end
        compared++; if (probe !== 1'b1) begin mismatched++; $display("[TB] FAIL fr_early_finish: busy %b before word 80, required 1", probe); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fr_busy_end: got %b, required 0", busy); end
        compared++; if (req_count - req_before !== 1) begin mismatched++; $display("[TB] FAIL fr_request_count: got %0d, required 1", req_count - req_before); end
    endtask

    task automatic test_back_to_back();
        int words, bad;
        logic probe;
        base_address = 23'h2000;
        first_row    = 23'h2000;
        send_cmd(2'd1, 6'd50, 7'd0, 32'h1234_5678);
        step();
        compared++; if (wr_address !== 23'h2FA0) begin mismatched++; $display("[TB] FAIL b2b_last_row_address: got %h, required 2fa0", wr_address); end
        step();
        drive_burst(COLUMNS, 32'h1234_5678, 1, 1'b1, 1'b0, words, bad, probe);
        compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL b2b_fill_data: got %0d bad words, required 0", bad); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_done_with_last: busy %b, required 0", busy); end
        send_cmd(2'd0, 6'd50, 7'd79, 32'hCAFE_0001);
        step();
        compared++; if (wr_address !== 23'h2FEF) begin mismatched++; $display("[TB] FAIL b2b_last_cell_address: got %h, required 2fef", wr_address); end
        step();
        drive_burst(1, 32'hCAFE_0001, 0, 1'b1, 1'b0, words, bad, probe);
        compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL b2b_cell_data: got %0d bad words, required 0", bad); end
        first_row = 23'h2000 + 23'd800;
        send_cmd(2'd0, 6'd45, 7'd2, 32'hCAFE_0002);
        step();
        compared++; if (wr_address !== 23'h2142) begin mismatched++; $display("[TB] FAIL b2b_cell_wrap_address: got %h, required 2142", wr_address); end
        compared++; if (wr_data !== 32'hCAFE_0002) begin mismatched++; $display("[TB] FAIL b2b_cell_wrap_data: got %h, required cafe0002", wr_data); end
        step();
        drive_burst(1, 32'hCAFE_0002, 0, 1'b0, 1'b0, words, bad, probe);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        int words, bad;
        logic probe;
        base_address = 23'h1000;
        first_row    = 23'h1000;
        send_cmd(2'd1, 6'd2, 7'd0, 32'h5555_AAAA);
        step();
        step();
        for (int w = 0; w < 40; w++) begin
            wr_next = 1'b1;
            step();
        end
        wr_next = 1'b0;
        #1 reset = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_busy: got %b, required 0", busy); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reset_cmd_ready: got %b, required 1", cmd_ready); end
        compared++; if (wr_address !== 23'h0) begin mismatched++; $display("[TB] FAIL mid_reset_address: got %h, required 0", wr_address); end
        compared++; if (wr_burst_length !== 9'd0) begin mismatched++; $display("[TB] FAIL mid_reset_length: got %0d, required 0", wr_burst_length); end
        compared++; if (wr_data !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_reset_data: got %h, required 0", wr_data); end
        step();
        reset = 1'b1;
        step();
        send_cmd(2'd0, 6'd1, 7'd0, 32'h0000_0077);
        step();
        compared++; if (wr_request !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_request: got %b, required 1", wr_request); end
        compared++; if (wr_address !== 23'h1050) begin mismatched++; $display("[TB] FAIL post_reset_address: got %h, required 1050", wr_address); end
        step();
        drive_burst(1, 32'h0000_0077, 0, 1'b1, 1'b0, words, bad, probe);
        compared++; if (bad !== 0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_burst: got %0d bad words busy %b, required 0 and 0", bad, busy); end
    endtask

    task automatic test_invalid();
        logic [1:0] ops [3];
        logic [5:0] rows [3];
        logic [6:0] cols [3];
        int req_before;
        ops[0] = 2'd0; rows[0] = 6'd0;  cols[0] = 7'd80;
        ops[1] = 2'd1; rows[1] = 6'd51; cols[1] = 7'd0;
        ops[2] = 2'd3; rows[2] = 6'd4;  cols[2] = 7'd4;
        for (int i = 0; i < 3; i++) begin
            req_before = req_count;
            send_cmd(ops[i], rows[i], cols[i], 32'hBAD0_0000 + i);
            compared++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL invalid_%0d_idle: got busy %b ready %b, required 0 and 1", i, busy, cmd_ready); end
            repeat (10) step();
            compared++; if (req_count - req_before !== 0) begin mismatched++; $display("[TB] FAIL invalid_%0d_requests: got %0d, required 0", i, req_count - req_before); end
        end
    endtask

    task automatic test_fill_page();
        int req_before;
`ifdef TEXT_WRITER_FILL_PAGE_EN
        int words, bad, total_words, data_bad, addr_bad, timeouts, waited;
        logic probe;
        logic [22:0] exp_addr;
        total_words = 0;
        data_bad    = 0;
        addr_bad    = 0;
        timeouts    = 0;
        base_address = 23'h3000;
        first_row    = 23'h3000 + 23'd1600;
        req_before   = req_count;
        send_cmd(2'd2, 6'd0, 7'd0, 32'h0020_0720);
        for (int r = 0; r < ROWS; r++) begin
            waited = 0;
            while (wr_request !== 1'b1 && waited < 6) begin
                step();
                waited++;
            end
            if (wr_request !== 1'b1) begin
                timeouts++;
                break;
            end
            exp_addr = 23'(32'h3000 + ((20 + r) % ROWS) * 80);
            if (wr_address !== exp_addr || wr_burst_length !== 9'd80) addr_bad++;
            step();
            drive_burst(COLUMNS, 32'h0020_0720, 0, r[0], 1'b0, words, bad, probe);
            total_words += words;
            data_bad    += bad;
        end
        compared++; if (timeouts !== 0) begin mismatched++; $display("[TB] FAIL fp_request_timeout: got %0d timeouts, required 0", timeouts); end
        compared++; if (req_count - req_before !== ROWS) begin mismatched++; $display("[TB] FAIL fp_burst_count: got %0d, required %0d", req_count - req_before, ROWS); end
        compared++; if (addr_bad !== 0) begin mismatched++; $display("[TB] FAIL fp_addresses: got %0d wrong, required 0", addr_bad); end
        compared++; if (total_words !== 4080) begin mismatched++; $display("[TB] FAIL fp_total_words: got %0d, required 4080", total_words); end
        compared++; if (data_bad !== 0) begin mismatched++; $display("[TB] FAIL fp_data: got %0d bad words, required 0", data_bad); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fp_busy_end: got %b, required 0", busy); end
`else
        req_before = req_count;
        send_cmd(2'd2, 6'd0, 7'd0, 32'h0020_0720);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fp_disabled_busy: got %b, required 0", busy); end
        repeat (10) step();
        compared++; if (req_count - req_before !== 0) begin mismatched++; $display("[TB] FAIL fp_disabled_requests: got %0d, required 0", req_count - req_before); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_cell();
        test_fill_row_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        test_invalid();
        test_fill_page();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Write-side counterpart of the video controller's character/attribute row fetch.
- Accepts cell-level and row-level commands from the terminal core and turns them into SDRAM write bursts into the circular text page.
- Computes the page address from `base_address` and `first_row`, with the same ring wrap the video controller uses when reading.

Parameters:
- COLUMNS, 80, cells per row; maximum burst length.
- ROWS, 51, rows per page.
- ROW_SIZE, 80, 32-bit words per row in SDRAM.
- PAGE_SIZE, 4080, words per page (ROWS × ROW_SIZE).

Ports:
- clk  in  1  system clock (108 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- base_address  in  23  first word of the page ring.
- first_row  in  23  SDRAM address of the displayed row 0.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when `cmd_valid && cmd_ready`.
- cmd_op  in  2  command code: 0 = WRITE_CELL, 1 = FILL_ROW, 2 = FILL_PAGE, 3 = NOP.
- cmd_row  in  6  screen row, 0..ROWS-1.
- cmd_col  in  7  screen column, 0..COLUMNS-1.
- cmd_data  in  32  charattr word, or fill value.
- wr_request  out  1  one-cycle burst start pulse.
- wr_address  out  23  burst start address.
- wr_burst_length  out  9  words in the burst.
- wr_data  out  32  current write word.
- wr_next  in  1  controller consumed `wr_data`; present the next word on the following cycle.
- wr_done  in  1  burst complete.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: `cmd_ready`=1, `wr_request`=0, `wr_address`=0, `wr_burst_length`=0, `wr_data`=0, `busy`=0; FSM in IDLE. An asynchronous reset mid-burst abandons the burst.
- FSM states: IDLE -> ADDR -> REQUEST -> BURST -> WAIT_DONE -> IDLE, or -> ADDR when another row is pending.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch op, row, col and data; drop `cmd_ready` on the next cycle.
  - NOP, or `cmd_row` ≥ ROWS, or `cmd_col` ≥ COLUMNS on WRITE_CELL: accepted and discarded, FSM stays in IDLE.
- ADDR (1 cycle):
  - Compute `off = row*ROW_SIZE` as `(row<<6)+(row<<4)`.
  - Compute `a = first_row + off` in 24 bits.
  - If `a ≥ base_address + PAGE_SIZE`, then `a = a - PAGE_SIZE`.
  - WRITE_CELL adds `col` after the wrap. A row never straddles the wrap point.
- REQUEST:
  - Drive `wr_address` = a and `wr_burst_length` = 1 (WRITE_CELL) or COLUMNS (fills).
  - Pulse `wr_request` for exactly 1 cycle; `wr_data` = latched data.
- BURST:
  - Each `wr_next` increments the word counter; `wr_data` stays at the latched value for every word.
  - After `wr_burst_length` `wr_next` pulses, go to WAIT_DONE.
  - Extra `wr_next` pulses beyond the length are ignored.
- WAIT_DONE:
  - On `wr_done`, go to IDLE; for FILL_PAGE with row < ROWS-1, increment row and go to ADDR.
  - `wr_done` arriving in the same cycle as the last `wr_next` completes the burst immediately.
- Latency: command handshake to `wr_request` is exactly 2 cycles.
- `base_address` and `first_row` are sampled in ADDR only. Changes while a command is in flight affect the next row only.
- `cmd_valid` while busy: held off by `cmd_ready`=0; the source keeps `cmd_*` stable.
- All address arithmetic is unsigned; results are truncated to 23 bits.

Optional Feature:
- Macro: TEXT_WRITER_FILL_PAGE_EN.
- Defined: FILL_PAGE writes rows 0..ROWS-1 as ROWS consecutive COLUMNS-word bursts with the fill value. Each row's address is recomputed with wrap.
- Undefined: FILL_PAGE is treated as NOP (accepted, discarded, no SDRAM traffic) and the row-loop logic is omitted.

Decomposition:
- Shared constants go in the common constant include: ROW_SIZE, PAGE_SIZE, COLUMNS, and the `cmd_op` codes (TW_WRITE_CELL, TW_FILL_ROW, TW_FILL_PAGE, TW_NOP), alongside the TRUE/FALSE constants.
- One sub-module: `text_row_address`, combinational, taking (base_address, first_row, row, col) and producing the wrapped address. It is shared with any future reader-side address logic.

Test Plan:
- WRITE_CELL row=0, col=5, data=0x0041_0F00, first_row=base=0x1000 -> `wr_request` 2 cycles after handshake; address 0x1005, length 1; one `wr_next` carries 0x00410F00.
- FILL_ROW row=3, first_row=0x1000+4000, base=0x1000 -> address wraps to 0x1000+4240-4080=0x10A0; length 80; 80 `wr_next` pulses, all carrying the fill word.
- Controller stalls `wr_next` randomly for 0..5 cycles -> exactly 80 words emitted, no duplicates; `busy` drops 1 cycle after `wr_done`.
- Reset asserted low mid-BURST at word 40 -> all outputs return to reset values immediately; next command starts cleanly.
- Invalid input (col=80 on WRITE_CELL, row=51, op=NOP) -> handshake completes, no `wr_request` within 10 cycles.
- With TEXT_WRITER_FILL_PAGE_EN: FILL_PAGE -> 51 bursts with ascending wrapped addresses, total 4080 words. Without the macro -> zero bursts.
